apb_master: RTL
===============

# apb_master

Bridge between the RV32I core's data-bus port and the APB peripheral bus. It turns one CPU load/store request into a two-phase APB transfer (SETUP, then ACCESS) and decodes the address into one PSEL line per peripheral. It multiplexes the selected peripheral's PRDATA/PREADY back to the core and reports decode misses and unresponsive slaves as errors. It sits directly upstream of the GPIO/UART/register-file APB slaves.

## Interface
- NUM_SLV, 4, number of APB slaves; 1..16
- BASE_ADDR, 32'h1000_0000, base of the APB window; bits [15:0] must be zero
- TIMEOUT, 16, maximum ACCESS cycles to wait for PREADY before aborting; ≥2

Ports:
- PCLK  in  1  bus clock, single clock domain
- PRESET  in  1  synchronous, active-high reset
- transfer  in  1  CPU request strobe, sampled only in IDLE
- write  in  1  1 = store, 0 = load
- addr  in  32  CPU byte address
- wdata  in  32  store data
- rdata  out  32  load data, valid while ready=1 and write=0 latched
- ready  out  1  one-cycle completion pulse
- err  out  1  one-cycle error pulse, coincident with ready
- PADDR  out  32  latched address
- PWRITE  out  1  latched write
- PWDATA  out  32  latched wdata
- PENABLE  out  1  high in ACCESS only
- PSEL  out  NUM_SLV  one-hot slave select
- PRDATA  in  32*NUM_SLV  flattened slave read data; slave i at [32i+31:32i]
- PREADY  in  NUM_SLV  per-slave ready

## Operation
- Decode: hit when addr[31:16]==BASE_ADDR[31:16] and addr[15:12] < NUM_SLV; index = addr[15:12].
- States: IDLE, SETUP, ACCESS, DONE.
- IDLE: transfer=1 → latch addr/write/wdata/index/hit. Hit → SETUP; miss → DONE with err flag set, no APB activity.
- SETUP (exactly 1 cycle): PSEL[index]=1, PENABLE=0 → ACCESS.
- ACCESS: PSEL[index]=1, PENABLE=1. PREADY[index]=1 → capture PRDATA slice into rdata (reads only), → DONE. Timeout counter reaches TIMEOUT with no PREADY → err flag set, → DONE.
- DONE (1 cycle): ready=1, err=flag, PSEL=0, PENABLE=0 → IDLE.
- PREADY/PRDATA are ignored outside ACCESS, and so are PREADY bits of unselected slaves.
- PADDR/PWRITE/PWDATA hold their latched values from SETUP until the next request is latched.
- rdata holds its value until the next read completes. On write or error it is not updated.

## Timing
- Reset (sync, PRESET=1 at a PCLK edge): state=IDLE, counter=0, every output = 0 including PADDR/PWDATA/rdata. Reset during SETUP/ACCESS abandons the transfer with no ready pulse.
- Request sampled at edge 0 → SETUP in cycle 1 → ACCESS from cycle 2. Completion edge is the first edge in ACCESS with PREADY[index]=1. DONE (ready pulse) follows in the next cycle.
- With a registered-PREADY slave: ACCESS in cycles 2–3, ready in cycle 4; total 4 cycles per transfer.
- Decode miss: ready+err in cycle 1.
- Timeout: the counter clears on SETUP→ACCESS and increments each ACCESS cycle. On ACCESS cycle number TIMEOUT without PREADY, the FSM moves → DONE.
- PREADY on the same edge the counter hits TIMEOUT: the transfer completes normally, err=0.
- transfer held high through a transaction does not re-launch until IDLE. Back-to-back requests restart SETUP one cycle after DONE.

## Structure
- Package apb_pkg: state enum (IDLE, SETUP, ACCESS, DONE), address-window constants (slave window width 4 KB, index field [15:12]), shared APB data width 32.
- Sub-module apb_addr_decoder: combinational addr → {hit, index, one-hot select}. It is reused by any future APB interconnect.
- Top: FSM, latches, timeout counter, PRDATA/PREADY mux.

## Test plan
- Write 0xDEADBEEF to 0x1000_0004 (slave 0), with a registered-PREADY slave:
  - PSEL[0]=1 in cycles 1–3, PENABLE=1 in cycles 2–3, PADDR=0x1000_0004.
  - ready=1, err=0 in cycle 4.
  - A following read of the same address returns rdata=0xDEADBEEF.
- Read 0x1000_300C (slave 3) with a slave returning 0x1234_5678: only PSEL[3] is asserted, rdata=0x1234_5678 on the ready pulse, and PRDATA of other slaves driven 0xFFFF_FFFF has no effect.
- Decode miss: 0x2000_0000 and 0x1000_4000 (NUM_SLV=4) give ready=err=1 in cycle 1, PSEL=0, PENABLE=0 throughout.
- Timeout: PREADY tied 0 gives exactly 16 ACCESS cycles, then ready=err=1, then IDLE. PREADY asserted on the 16th ACCESS cycle gives err=0.
- Back-to-back: transfer held high for three writes gives three ready pulses at 5-cycle spacing, with an IDLE cycle between DONE and SETUP.
- PRESET asserted in the second ACCESS cycle: the next cycle has all outputs 0, state IDLE and no ready pulse. A new request after reset completes normally.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB definitions: bridge FSM states, data width and the slave address map.
package apb_pkg;

  localparam int APB_DATA_W   = 32;
  localparam int APB_ADDR_W   = 32;
  localparam int SLV_WIN_BITS = 12;  // 4 KB window per slave
  localparam int IDX_LSB      = SLV_WIN_BITS;
  localparam int IDX_MSB      = 15;
  localparam int IDX_W        = IDX_MSB - IDX_LSB + 1;
  localparam int BASE_LSB     = IDX_MSB + 1;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DONE
  } apb_state_e;

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational APB address decoder: page address -> {hit, slave index, one-hot select}.
module apb_addr_decoder
  import apb_pkg::*;
#(
  parameter int          NUM_SLV   = 4,
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000
) (
  input  logic [APB_ADDR_W-1:IDX_LSB] addr,
  output logic                        hit,
  output logic [IDX_W-1:0]            index,
  output logic [NUM_SLV-1:0]          sel
);

  localparam int CMP_W = IDX_W + 1;

  always_comb begin
    index = addr[IDX_MSB:IDX_LSB];
    hit   = (addr[APB_ADDR_W-1:BASE_LSB] == BASE_ADDR[APB_ADDR_W-1:BASE_LSB]) &&
            ({1'b0, index} < CMP_W'(NUM_SLV));
    sel   = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      sel[i] = hit && (index == IDX_W'(i));
    end
  end

endmodule

// File: rtl/apb_master.sv
// CPU data-bus to APB bridge: one request becomes a SETUP/ACCESS transfer,
// with decode-miss and PREADY-timeout errors reported alongside the ready pulse.
module apb_master
  import apb_pkg::*;
#(
  parameter int          NUM_SLV   = 4,
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter int          TIMEOUT   = 16
) (
  input  logic                          PCLK,
  input  logic                          PRESET,
  input  logic                          transfer,
  input  logic                          write,
  input  logic [APB_ADDR_W-1:0]         addr,
  input  logic [APB_DATA_W-1:0]         wdata,
  output logic [APB_DATA_W-1:0]         rdata,
  output logic                          ready,
  output logic                          err,
  output logic [APB_ADDR_W-1:0]         PADDR,
  output logic                          PWRITE,
  output logic [APB_DATA_W-1:0]         PWDATA,
  output logic                          PENABLE,
  output logic [NUM_SLV-1:0]            PSEL,
  input  logic [APB_DATA_W*NUM_SLV-1:0] PRDATA,
  input  logic [NUM_SLV-1:0]            PREADY
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  apb_state_e              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    err_q, err_d;
  logic [APB_ADDR_W-1:0]   paddr_q, paddr_d;
  logic [APB_DATA_W-1:0]   pwdata_q, pwdata_d;
  logic                    pwrite_q, pwrite_d;
  logic [APB_DATA_W-1:0]   rdata_q, rdata_d;
  logic [IDX_W-1:0]        index_q, index_d;
  logic [NUM_SLV-1:0]      sel_q, sel_d;

  logic                    dec_hit;
  logic [IDX_W-1:0]        dec_index;
  logic [NUM_SLV-1:0]      dec_sel;
  logic                    slv_ready;
  logic [APB_DATA_W-1:0]   slv_rdata;

  apb_addr_decoder #(
    .NUM_SLV   (NUM_SLV),
    .BASE_ADDR (BASE_ADDR)
  ) u_decoder (
    .addr  (addr[APB_ADDR_W-1:IDX_LSB]),
    .hit   (dec_hit),
    .index (dec_index),
    .sel   (dec_sel)
  );

  // Only the latched slave's PREADY/PRDATA matter; all other slaves are masked.
  always_comb begin
    slv_ready = |(PREADY & sel_q);
    slv_rdata = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (index_q == IDX_W'(i)) begin
        slv_rdata = PRDATA[i*APB_DATA_W +: APB_DATA_W];
      end
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
      rdata_q  <= '0;
      index_q  <= '0;
      sel_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pwrite_q <= pwrite_d;
      rdata_q  <= rdata_d;
      index_q  <= index_d;
      sel_q    <= sel_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pwrite_d = pwrite_q;
    rdata_d  = rdata_q;
    index_d  = index_q;
    sel_d    = sel_q;
    unique case (state_q)
      IDLE: begin
        if (transfer) begin
          paddr_d  = addr;
          pwdata_d = wdata;
          pwrite_d = write;
          index_d  = dec_index;
          sel_d    = dec_sel;
          err_d    = !dec_hit;
          state_d  = dec_hit ? SETUP : DONE;
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        // PREADY wins over a timeout landing on the same edge.
        if (slv_ready) begin
          if (!pwrite_q) begin
            rdata_d = slv_rdata;
          end
          err_d   = 1'b0;
          state_d = DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    PSEL    = ((state_q == SETUP) || (state_q == ACCESS)) ? sel_q : '0;
    PENABLE = (state_q == ACCESS);
    ready   = (state_q == DONE);
    err     = (state_q == DONE) && err_q;
    PADDR   = paddr_q;
    PWDATA  = pwdata_q;
    PWRITE  = pwrite_q;
    rdata   = rdata_q;
  end

endmodule
